rv_lsu: RTL and testbench

RV_LSU -- requirements
Module: rv_lsu

---
 rtl/rv_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_rv_lsu.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu.sv
//============================================================================
// Module   : rv_lsu
// Brief    : Single-port load/store unit. Fetch, byte/half/word loads, and
//            word or read-modify-write sub-word stores on a word bus.
//            Optional macro RV_LSU_ALIGN_TRAP_EN turns misaligned requests
//            into an immediate fault completion instead of an aligned access.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module rv_lsu #(
  parameter int AW   = 32,
  parameter int WAIT = 0
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          ce,
  input  logic          req,
  input  logic [1:0]    cmd,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [AW-1:0] a,
  input  logic [31:0]   i,
  output logic [31:0]   o,
  output logic          w,
  output logic          busy,
  output logic          ack,
  output logic [31:0]   rdata,
  output logic          fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] c_cmd_fetch = 2'd0;
  localparam logic [1:0] c_cmd_store = 2'd2;
  localparam logic [1:0] c_size_byte = 2'd0;
  localparam logic [1:0] c_size_half = 2'd1;
  localparam logic [3:0] c_wait      = 4'(WAIT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [1:0]    r_cmd;
  logic [1:0]    r_size;
  logic          r_sext;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_wdata;
  logic [31:0]   r_o;
  logic [31:0]   r_rdata;

  logic          w_req_store_word;
  logic          w_trap;
  logic          w_rd_last;
  logic [7:0]    w_lane_byte;
  logic [15:0]   w_lane_half;
  logic [31:0]   w_load_data;
  logic [31:0]   w_merge_data;

  assign w_req_store_word = (cmd == c_cmd_store) && size[1];
  assign w_rd_last        = (r_cnt == c_wait);

`ifdef RV_LSU_ALIGN_TRAP_EN
  logic r_fault;

  // Fetch is always a word access regardless of size
  assign w_trap = ((cmd == c_cmd_fetch) || size[1]) ? (addr[1:0] != 2'b00)
                                                    : ((size == c_size_half) && addr[0]);
  assign fault  = r_fault;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (ce && (r_state == IDLE) && req) begin
      r_fault <= w_trap;
    end
  end
`else
  assign w_trap = 1'b0;
  assign fault  = 1'b0;
`endif

  assign a     = {r_addr[AW-1:2], 2'b00};
  assign o     = r_o;
  assign rdata = r_rdata;

  // Load extraction from the sampled bus word
  always_comb begin
    w_lane_byte = i[7:0];
    case (r_addr[1:0])
      2'd1:    w_lane_byte = i[15:8];
      2'd2:    w_lane_byte = i[23:16];
      2'd3:    w_lane_byte = i[31:24];
      default: w_lane_byte = i[7:0];
    endcase
    w_lane_half = r_addr[1] ? i[31:16] : i[15:0];
    if ((r_cmd == c_cmd_fetch) || r_size[1]) begin
      w_load_data = i;
    end else if (r_size == c_size_byte) begin
      w_load_data = {{24{r_sext & w_lane_byte[7]}}, w_lane_byte};
    end else begin
      w_load_data = {{16{r_sext & w_lane_half[15]}}, w_lane_half};
    end
  end

  // Read-modify-write merge for sub-word stores
  always_comb begin
    w_merge_data = i;
    if (r_size == c_size_byte) begin
      case (r_addr[1:0])
        2'd1:    w_merge_data[15:8]  = r_wdata[7:0];
        2'd2:    w_merge_data[23:16] = r_wdata[7:0];
        2'd3:    w_merge_data[31:24] = r_wdata[7:0];
        default: w_merge_data[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merge_data[31:16] = r_wdata;
    end else begin
      w_merge_data[15:0] = r_wdata;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w           = 1'b0;
    busy        = 1'b1;
    ack         = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (w_trap) begin
            w_state_nxt = DONE;
          end else if (w_req_store_word) begin
            w_state_nxt = WR;
          end else begin
            w_state_nxt = RD;
          end
        end
      end
      RD: begin
        if (w_rd_last) begin
          w_state_nxt = (r_cmd == c_cmd_store) ? WR : DONE;
        end
      end
      WR: begin
        w           = ce;
        w_state_nxt = DONE;
      end
      DONE: begin
        ack         = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_cmd   <= 2'd0;
      r_size  <= 2'd0;
      r_sext  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 16'd0;
      r_o     <= 32'd0;
      r_rdata <= 32'd0;
    end else if (ce) begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_cmd   <= cmd;
            r_size  <= size;
            r_sext  <= sext;
            r_addr  <= addr;
            r_wdata <= wdata[15:0];
            r_cnt   <= 4'd0;
            if (w_trap) begin
              r_rdata <= 32'd0;
            end else if (w_req_store_word) begin
              r_o <= wdata;
            end
          end
        end
        RD: begin
          if (w_rd_last) begin
            r_cnt <= 4'd0;
            if (r_cmd == c_cmd_store) begin
              r_o <= w_merge_data;
            end else begin
              r_rdata <= w_load_data;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        WR: r_rdata <= 32'd0;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_lsu.sv
//============================================================================
// Module   : tb_rv_lsu
// Brief    : Directed self-checking bench for rv_lsu; runs a WAIT=0 and a
//            WAIT=3 instance side by side, each with its own word memory.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_rv_lsu;

`ifdef RV_LSU_ALIGN_TRAP_EN
  localparam bit c_trap = 1'b1;
`else
  localparam bit c_trap = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst, ce, req, sext;
  logic [1:0]  cmd, size;
  logic [31:0] addr, wdata;
  logic [31:0] a0, i0, o0, rdata0, a3, i3, o3, rdata3;
  logic        w0, busy0, ack0, fault0, w3, busy3, ack3, fault3;
  logic [31:0] mem0 [0:127];
  logic [31:0] mem3 [0:127];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wcnt0   = 0;
  int          wcnt3   = 0;

  always #5 clock = ~clock;

  assign i0 = mem0[a0[8:2]];
  assign i3 = mem3[a3[8:2]];

  rv_lsu #(.AW(32), .WAIT(0)) u_dut0 (
    .clock(clock), .rst(rst), .ce(ce), .req(req), .cmd(cmd), .size(size),
    .sext(sext), .addr(addr), .wdata(wdata), .a(a0), .i(i0), .o(o0), .w(w0),
    .busy(busy0), .ack(ack0), .rdata(rdata0), .fault(fault0)
  );

  rv_lsu #(.AW(32), .WAIT(3)) u_dut3 (
    .clock(clock), .rst(rst), .ce(ce), .req(req), .cmd(cmd), .size(size),
    .sext(sext), .addr(addr), .wdata(wdata), .a(a3), .i(i3), .o(o3), .w(w3),
    .busy(busy3), .ack(ack3), .rdata(rdata3), .fault(fault3)
  );

  typedef struct packed {
    logic [1:0]  cmd;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
    logic        mis;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One clock; bus writes commit at the edge that ends the strobe cycle
  task automatic tick();
    logic        wv0, wv3;
    logic [31:0] wa0, wd0, wa3, wd3;
    @(negedge clock);
    wv0 = w0; wa0 = a0; wd0 = o0;
    wv3 = w3; wa3 = a3; wd3 = o3;
    @(posedge clock);
    if (wv0) begin mem0[wa0[8:2]] = wd0; wcnt0++; end
    if (wv3) begin mem3[wa3[8:2]] = wd3; wcnt3++; end
    #1;
  endtask

  // Presents a request for the acceptance edge, then scrambles the inputs
  task automatic issue(input logic [1:0] c, input logic [1:0] sz, input logic sx,
                       input logic [31:0] ad, input logic [31:0] wd);
    cmd = c; size = sz; sext = sx; addr = ad; wdata = wd; req = 1'b1;
    tick();
    req = 1'b0; cmd = 2'd2; size = 2'd3; sext = ~sx;
    addr = 32'hFFFF_FFFC; wdata = 32'h5A5A_5A5A;
  endtask

  task automatic collect(input int k_start, output int lat0, output int lat3,
                         output logic [31:0] rd0, output logic [31:0] rd3,
                         output logic f0, output logic f3);
    lat0 = 0; lat3 = 0; rd0 = '0; rd3 = '0; f0 = 1'b0; f3 = 1'b0;
    for (int k = k_start; k < k_start + 40; k++) begin
      if (ack0 && lat0 == 0) begin lat0 = k; rd0 = rdata0; f0 = fault0; end
      if (ack3 && lat3 == 0) begin lat3 = k; rd3 = rdata3; f3 = fault3; end
      if (lat0 != 0 && lat3 != 0) break;
      tick();
    end
    tick();
  endtask

  function automatic int exp_lat(input int wt, input logic [1:0] c,
                                 input logic [1:0] sz, input logic trapped);
    if (trapped) return 1;
    if (c == 2'd2) return sz[1] ? 2 : wt + 3;
    return wt + 2;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat0, lat3, w0s, w3s, ewr;
    logic [31:0] rd0, rd3, erd, emem;
    logic        f0, f3, trapped;
    logic [6:0]  idx;
    vec_t        v;

    //           cmd   size  sx    addr          wdata         init          exp_rdata     exp_mem       mis
    vecs[0]  = '{2'd1, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        32'h1122_3344, 32'h1122_3344, 32'h1122_3344, 1'b0};
    vecs[1]  = '{2'd2, 2'd0, 1'b0, 32'h0000_0021, 32'h0000_0055, 32'hAABB_CCDD, 32'h0,        32'hAABB_55DD, 1'b0};
    vecs[2]  = '{2'd1, 2'd0, 1'b1, 32'h0000_0023, 32'h0,        32'h8000_0000, 32'hFFFF_FF80, 32'h8000_0000, 1'b0};
    vecs[3]  = '{2'd1, 2'd0, 1'b0, 32'h0000_0023, 32'h0,        32'h8000_0000, 32'h0000_0080, 32'h8000_0000, 1'b0};
    vecs[4]  = '{2'd0, 2'd0, 1'b1, 32'h0000_0040, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{2'd1, 2'd1, 1'b1, 32'h0000_0046, 32'h0,        32'h8001_7FFF, 32'hFFFF_8001, 32'h8001_7FFF, 1'b0};
    vecs[6]  = '{2'd1, 2'd1, 1'b0, 32'h0000_0044, 32'h0,        32'h1234_F00D, 32'h0000_F00D, 32'h1234_F00D, 1'b0};
    vecs[7]  = '{2'd1, 2'd0, 1'b1, 32'h0000_0048, 32'h0,        32'h0000_007F, 32'h0000_007F, 32'h0000_007F, 1'b0};
    vecs[8]  = '{2'd2, 2'd2, 1'b0, 32'h0000_0050, 32'hCAFE_BABE, 32'h1111_1111, 32'h0,        32'hCAFE_BABE, 1'b0};
    vecs[9]  = '{2'd2, 2'd1, 1'b0, 32'h0000_0056, 32'h9999_BEEF, 32'h1234_5678, 32'h0,        32'hBEEF_5678, 1'b0};
    vecs[10] = '{2'd2, 2'd0, 1'b0, 32'h0000_005B, 32'h0000_00A5, 32'h0000_0000, 32'h0,        32'hA500_0000, 1'b0};
    vecs[11] = '{2'd3, 2'd3, 1'b0, 32'h0000_0060, 32'h0,        32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
    vecs[12] = '{2'd1, 2'd2, 1'b0, 32'h0000_0102, 32'h0,        32'h0102_0304, 32'h0102_0304, 32'h0102_0304, 1'b1};
    vecs[13] = '{2'd1, 2'd1, 1'b1, 32'h0000_0065, 32'h0,        32'hAABB_CCDD, 32'hFFFF_CCDD, 32'hAABB_CCDD, 1'b1};
    vecs[14] = '{2'd0, 2'd2, 1'b0, 32'h0000_006A, 32'h0,        32'h5566_7788, 32'h5566_7788, 32'h5566_7788, 1'b1};
    vecs[15] = '{2'd2, 2'd1, 1'b0, 32'h0000_0071, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_1234, 1'b1};

    for (int j = 0; j < 128; j++) begin mem0[j] = 32'h0; mem3[j] = 32'h0; end
    rst = 1'b1; ce = 1'b1; req = 1'b0; cmd = 2'd0; size = 2'd0; sext = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    #1;
    tick(); tick();
    chk("rst a",     a0,     32'h0);
    chk("rst o",     o0,     32'h0);
    chk("rst w",     w0,     1'b0);
    chk("rst busy",  busy0,  1'b0);
    chk("rst ack",   ack0,   1'b0);
    chk("rst rdata", rdata0, 32'h0);
    chk("rst fault", fault0, 1'b0);
    chk("rst a3",    a3,     32'h0);
    rst = 1'b0;
    tick();

    for (int n = 0; n < 16; n++) begin
      v   = vecs[n];
      idx = v.addr[8:2];
      mem0[idx] = v.init;
      mem3[idx] = v.init;
      w0s = wcnt0; w3s = wcnt3;
      trapped = c_trap && v.mis;
      issue(v.cmd, v.size, v.sext, v.addr, v.wdata);
      collect(1, lat0, lat3, rd0, rd3, f0, f3);
      erd  = trapped ? 32'h0 : v.exp_rdata;
      emem = trapped ? v.init : v.exp_mem;
      ewr  = (v.cmd == 2'd2 && !trapped) ? 1 : 0;
      chk($sformatf("v%0d lat0", n),   lat0, exp_lat(0, v.cmd, v.size, trapped));
      chk($sformatf("v%0d lat3", n),   lat3, exp_lat(3, v.cmd, v.size, trapped));
      chk($sformatf("v%0d rdata0", n), rd0, erd);
      chk($sformatf("v%0d rdata3", n), rd3, erd);
      chk($sformatf("v%0d fault0", n), f0, trapped);
      chk($sformatf("v%0d fault3", n), f3, trapped);
      chk($sformatf("v%0d mem0", n),   mem0[idx], emem);
      chk($sformatf("v%0d mem3", n),   mem3[idx], emem);
      chk($sformatf("v%0d writes0", n), wcnt0 - w0s, ewr);
      chk($sformatf("v%0d writes3", n), wcnt3 - w3s, ewr);
    end

    // Fetch frozen by ce=0 for four cycles while in RD
    mem0[16] = 32'hDEAD_BEEF; mem3[16] = 32'hDEAD_BEEF;
    w0s = wcnt0; w3s = wcnt3;
    issue(2'd0, 2'd2, 1'b0, 32'h0000_0040, 32'h0);
    ce = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("frz busy0", busy0, 1'b1);
      chk("frz ack0",  ack0,  1'b0);
      chk("frz ack3",  ack3,  1'b0);
      tick();
    end
    ce = 1'b1;
    collect(5, lat0, lat3, rd0, rd3, f0, f3);
    chk("frz lat0",    lat0, 6);
    chk("frz lat3",    lat3, 9);
    chk("frz rdata0",  rd0,  32'hDEAD_BEEF);
    chk("frz rdata3",  rd3,  32'hDEAD_BEEF);
    chk("frz writes0", wcnt0 - w0s, 0);
    tick(); tick(); tick();
    chk("rdata hold0", rdata0, 32'hDEAD_BEEF);
    chk("rdata hold3", rdata3, 32'hDEAD_BEEF);

    // Word store with ce low during WR: strobe gated, write still happens once
    mem0[33] = 32'h0; mem3[33] = 32'h0;
    w0s = wcnt0; w3s = wcnt3;
    issue(2'd2, 2'd2, 1'b0, 32'h0000_0084, 32'h7654_3210);
    chk("wr w0 pre", w0, 1'b1);
    ce = 1'b0;
    #1;
    chk("wr gated w0", w0, 1'b0);
    chk("wr gated w3", w3, 1'b0);
    tick(); tick();
    ce = 1'b1;
    collect(3, lat0, lat3, rd0, rd3, f0, f3);
    chk("wr gated lat0",    lat0, 4);
    chk("wr gated lat3",    lat3, 4);
    chk("wr gated mem0",    mem0[33], 32'h7654_3210);
    chk("wr gated writes0", wcnt0 - w0s, 1);
    chk("wr gated writes3", wcnt3 - w3s, 1);

    // Reset during WR of a half store aborts the access
    mem0[32] = 32'h1111_2222; mem3[32] = 32'h1111_2222;
    w0s = wcnt0; w3s = wcnt3;
    issue(2'd2, 2'd1, 1'b0, 32'h0000_0082, 32'h0000_ABCD);
    tick();
    chk("abort w0 pre", w0, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort w0",    w0,    1'b0);
    chk("abort busy0", busy0, 1'b0);
    chk("abort a0",    a0,    32'h0);
    chk("abort busy3", busy3, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("abort mem0",    mem0[32], 32'h1111_2222);
    chk("abort mem3",    mem3[32], 32'h1111_2222);
    chk("abort writes0", wcnt0 - w0s, 0);
    chk("abort writes3", wcnt3 - w3s, 0);
    issue(2'd1, 2'd2, 1'b0, 32'h0000_0080, 32'h0);
    collect(1, lat0, lat3, rd0, rd3, f0, f3);
    chk("post rst rdata0", rd0, 32'h1111_2222);
    chk("post rst lat3",   lat3, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
